// File: rtl/mem_stage_sram_ctrl.sv
// MEM pipeline stage: runs loads/stores against a word SRAM over a req/ack handshake,
// stalls the upstream pipeline while an access is in flight and forwards results to MEM/WB.
module mem_stage_sram_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          SRAM_AW     = 18,
    parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               WB_EN_MEM,
    input  logic [1:0]         MEM_CMD_MEM,
    input  logic [31:0]        ALU_res_MEM,
    input  logic [31:0]        src2_val_MEM,
    input  logic [4:0]         Dst_MEM,
    output logic               WB_EN_out_MEM,
    output logic               MEM_R_EN_out,
    output logic [31:0]        ALU_res_out,
    output logic [31:0]        mem_rdata_out,
    output logic [4:0]         Dst_out_MEM,
    output logic               freeze,
    output logic               bus_err,
    output logic               sram_req,
    output logic               sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata,
    input  logic               sram_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q;
    logic               is_mem_op;
    logic               timeout_hit;
    logic               freeze_c;
    logic               addr_borrow;
    logic [SRAM_AW-1:0] word_addr;

    assign is_mem_op   = (MEM_CMD_MEM == 2'b10) || (MEM_CMD_MEM == 2'b01);
    assign timeout_hit = (cnt_q == ACK_TIMEOUT - 8'd1);

    // Word-granular subtract; the byte-offset borrow keeps it equal to ((a - base) >> 2).
    assign addr_borrow = (ALU_res_MEM[1:0] < BASE_ADDR[1:0]);
    assign word_addr   = ALU_res_MEM[SRAM_AW+1:2] - BASE_ADDR[SRAM_AW+1:2]
                       - {{(SRAM_AW-1){1'b0}}, addr_borrow};

    always_comb begin
        state_d  = state_q;
        freeze_c = 1'b0;
        case (state_q)
            IDLE: begin
                freeze_c = is_mem_op;
                if (is_mem_op)
                    state_d = ACCESS;
            end
            ACCESS: begin
                freeze_c = 1'b1;
                if (sram_ack || timeout_hit)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset must release the pipeline at once, even while the EXE/MEM register still holds a mem op.
    assign freeze        = freeze_c & ~rst;
    assign WB_EN_out_MEM = WB_EN_MEM & ~freeze;
    assign MEM_R_EN_out  = (MEM_CMD_MEM == 2'b10);
    assign ALU_res_out   = ALU_res_MEM;
    assign Dst_out_MEM   = Dst_MEM;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            sram_req      <= 1'b0;
            sram_we       <= 1'b0;
            sram_addr     <= '0;
            sram_wdata    <= 32'd0;
            mem_rdata_out <= 32'd0;
            bus_err       <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (is_mem_op) begin
                        sram_req   <= 1'b1;
                        sram_we    <= (MEM_CMD_MEM == 2'b01);
                        sram_addr  <= word_addr;
                        sram_wdata <= src2_val_MEM;
                        cnt_q      <= 8'd0;
                    end
                end
                ACCESS: begin
                    // A late ack in the limit cycle still counts as a normal completion.
                    if (sram_ack) begin
                        sram_req <= 1'b0;
                        if (!sram_we)
                            mem_rdata_out <= sram_rdata;
                    end else if (timeout_hit) begin
                        sram_req      <= 1'b0;
                        bus_err       <= 1'b1;
                        mem_rdata_out <= 32'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Randomized bench for mem_stage_sram_ctrl: a transaction-level model predicts stall length,
// SRAM address/data and load results; the bench also plays the SRAM.
module tb_mem_stage_sram_ctrl;

    localparam int SRAM_AW = 18;
    localparam int ACK_TO  = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               WB_EN_MEM;
    logic [1:0]         MEM_CMD_MEM;
    logic [31:0]        ALU_res_MEM;
    logic [31:0]        src2_val_MEM;
    logic [4:0]         Dst_MEM;
    logic               WB_EN_out_MEM;
    logic               MEM_R_EN_out;
    logic [31:0]        ALU_res_out;
    logic [31:0]        mem_rdata_out;
    logic [4:0]         Dst_out_MEM;
    logic               freeze;
    logic               bus_err;
    logic               sram_req;
    logic               sram_we;
    logic [SRAM_AW-1:0] sram_addr;
    logic [31:0]        sram_wdata;
    logic [31:0]        sram_rdata;
    logic               sram_ack;

    mem_stage_sram_ctrl #(
        .BASE_ADDR  (32'd1024),
        .SRAM_AW    (SRAM_AW),
        .ACK_TIMEOUT(8'(ACK_TO))
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .WB_EN_MEM    (WB_EN_MEM),
        .MEM_CMD_MEM  (MEM_CMD_MEM),
        .ALU_res_MEM  (ALU_res_MEM),
        .src2_val_MEM (src2_val_MEM),
        .Dst_MEM      (Dst_MEM),
        .WB_EN_out_MEM(WB_EN_out_MEM),
        .MEM_R_EN_out (MEM_R_EN_out),
        .ALU_res_out  (ALU_res_out),
        .mem_rdata_out(mem_rdata_out),
        .Dst_out_MEM  (Dst_out_MEM),
        .freeze       (freeze),
        .bus_err      (bus_err),
        .sram_req     (sram_req),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ack     (sram_ack)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] ref_mem  [int];
    logic [31:0] sram_mem [int];
    logic [31:0] exp_rdata;
    logic        exp_berr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int word_key(input logic [31:0] byte_addr);
        logic [31:0] d;
        d = byte_addr - 32'd1024;
        return int'((d / 32'd4) % 32'd262144);
    endfunction

    // One instruction held in EXE/MEM until the stage lets it go. lat = ACCESS cycle that
    // carries the ack (1..ACK_TO), anything else means the SRAM never answers in time.
    task automatic run_op(input logic [1:0] cmd, input logic [31:0] alu, input logic [31:0] wd,
                          input logic wb, input logic [4:0] dst, input int lat);
        bit is_mem, acked, is_st, exp_frz, exp_req;
        int len, key;
        is_mem = (cmd == 2'b01) || (cmd == 2'b10);
        is_st  = (cmd == 2'b01);
        acked  = is_mem && (lat >= 1) && (lat <= ACK_TO);
        len    = !is_mem ? 1 : ((acked ? lat : ACK_TO) + 2);
        key    = word_key(alu);
        WB_EN_MEM    = wb;
        MEM_CMD_MEM  = cmd;
        ALU_res_MEM  = alu;
        src2_val_MEM = wd;
        Dst_MEM      = dst;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            exp_frz = is_mem && (i < len - 1);
            exp_req = is_mem && (i >= 1) && (i < len - 1);
            check_val("freeze", 32'(freeze), 32'(exp_frz));
            check_val("wb_en_out", 32'(WB_EN_out_MEM), 32'(wb & ~exp_frz));
            check_val("sram_req", 32'(sram_req), 32'(exp_req));
            if (is_mem && i == 1) begin
                check_val("sram_addr", 32'(sram_addr), 32'(key));
                check_val("sram_we", 32'(sram_we), 32'(is_st));
                if (is_st)
                    check_val("sram_wdata", sram_wdata, wd);
            end
            if (exp_req) begin
                sram_ack   = acked && (i == lat);
                sram_rdata = $urandom;
                if (sram_ack) begin
                    if (sram_we)
                        sram_mem[int'(sram_addr)] = sram_wdata;
                    else
                        sram_rdata = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : 32'd0;
                end
            end else begin
                sram_ack   = 1'($urandom_range(0, 1));
                sram_rdata = $urandom;
            end
            if (i == len - 1) begin
                if (is_mem) begin
                    if (!acked) begin
                        exp_rdata = 32'd0;
                        exp_berr  = 1'b1;
                    end else if (is_st) begin
                        ref_mem[key] = wd;
                    end else begin
                        exp_rdata = ref_mem.exists(key) ? ref_mem[key] : 32'd0;
                    end
                end
                check_val("mem_rdata_out", mem_rdata_out, exp_rdata);
                check_val("bus_err", 32'(bus_err), 32'(exp_berr));
                check_val("mem_r_en_out", 32'(MEM_R_EN_out), 32'(cmd == 2'b10));
                check_val("alu_res_out", ALU_res_out, alu);
                check_val("dst_out", 32'(Dst_out_MEM), 32'(dst));
            end
        end
        @(posedge clk);
        #1;
        sram_ack = 1'b0;
    endtask

    initial begin
        logic [1:0]  cmd;
        logic [31:0] alu;
        rst          = 1'b1;
        WB_EN_MEM    = 1'b0;
        MEM_CMD_MEM  = 2'b00;
        ALU_res_MEM  = 32'd0;
        src2_val_MEM = 32'd0;
        Dst_MEM      = 5'd0;
        sram_ack     = 1'b0;
        sram_rdata   = 32'd0;
        exp_rdata    = 32'd0;
        exp_berr     = 1'b0;
        ref_mem[262143]  = 32'hDEAD_BEEF;
        sram_mem[262143] = 32'hDEAD_BEEF;

        repeat (2) @(negedge clk);
        check_val("rst_sram_req", 32'(sram_req), 32'd0);
        check_val("rst_sram_we", 32'(sram_we), 32'd0);
        check_val("rst_sram_addr", 32'(sram_addr), 32'd0);
        check_val("rst_sram_wdata", sram_wdata, 32'd0);
        check_val("rst_mem_rdata", mem_rdata_out, 32'd0);
        check_val("rst_bus_err", 32'(bus_err), 32'd0);
        check_val("rst_freeze", 32'(freeze), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(2'b01, 32'd1028, 32'hA5A5_0001, 1'b1, 5'd7, 3);
        run_op(2'b10, 32'd1028, 32'h0, 1'b1, 5'd8, 1);
        for (int k = 0; k < 5; k++)
            run_op(2'b00, $urandom, $urandom, 1'(k & 1), 5'(k + 1), 0);
        run_op(2'b10, 32'd1020, 32'h0, 1'b1, 5'd9, ACK_TO);
        run_op(2'b10, 32'd1100, 32'h0, 1'b1, 5'd10, 0);
        run_op(2'b00, 32'd5, 32'd0, 1'b1, 5'd11, 0);
        run_op(2'b11, 32'd1032, 32'd0, 1'b1, 5'd12, 1);
        run_op(2'b01, 32'd1032, 32'h0BAD_F00D, 1'b0, 5'd13, 2);

        // Asynchronous reset in the middle of an access.
        WB_EN_MEM   = 1'b1;
        MEM_CMD_MEM = 2'b10;
        ALU_res_MEM = 32'd1040;
        Dst_MEM     = 5'd3;
        @(negedge clk);
        sram_ack = 1'b0;
        @(negedge clk);
        check_val("pre_rst_req", 32'(sram_req), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("midrst_req", 32'(sram_req), 32'd0);
        check_val("midrst_freeze", 32'(freeze), 32'd0);
        MEM_CMD_MEM = 2'b00;
        @(negedge clk);
        rst        = 1'b0;
        exp_rdata  = 32'd0;
        exp_berr   = 1'b0;
        sram_ack   = 1'b1;
        sram_rdata = 32'h1234_5678;
        @(negedge clk);
        sram_ack = 1'b0;
        check_val("stray_ack_req", 32'(sram_req), 32'd0);
        check_val("stray_ack_freeze", 32'(freeze), 32'd0);
        check_val("stray_ack_rdata", mem_rdata_out, 32'd0);
        check_val("stray_ack_berr", 32'(bus_err), 32'd0);
        @(posedge clk);
        #1;

        for (int n = 0; n < 80; n++) begin
            cmd = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)
                alu = 32'd1024 - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
            else
                alu = 32'd1024 + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
            if (cmd == 2'b00 && $urandom_range(0, 1) == 1)
                alu = $urandom;
            run_op(cmd, alu, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   int'($urandom_range(0, 5)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
